mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16, which sets the ack-wait limit when MEM_ACK_TIMEOUT_EN is defined.
REQ-002 SHALL have port i_clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have EX/MEM inputs: i_valid 1, i_alu_out 32 (address or result), i_rd2 32 (store data), i_mem_read 1, i_mem_write 1, i_func3 3 (size/sign), i_rd 5, i_reg_write 1, i_mem_to_reg 1.
REQ-005 SHALL have port o_stall  out  1  that tells the EX stage to hold its EX/MEM outputs.
REQ-006 SHALL have a data-memory port: o_dmem_req out 1, o_dmem_we out 1, o_dmem_addr out 32 (word-aligned, [1:0]=0), o_dmem_be out 4, o_dmem_wdata out 32, i_dmem_ack in 1, i_dmem_rdata in 32.
REQ-007 SHALL have writeback outputs: o_wb_valid 1, o_wb_rd 5, o_wb_reg_write 1, o_wb_data 32.
REQ-008 SHALL have status pulse outputs o_misaligned 1 and o_bus_err 1.

Function
REQ-009 SHALL implement an FSM with states IDLE and ACCESS, and SHALL drive o_stall = (state==ACCESS).
REQ-010 SHALL accept inputs only in IDLE with i_valid=1.
- A non-memory op SHALL register i_alu_out, i_rd and i_reg_write to WB with o_wb_valid=1 on the next cycle (latency 1).
REQ-011 SHALL handle a memory op (i_mem_read or i_mem_write) accepted in IDLE as follows:
- latch operands;
- enter ACCESS;
- assert o_dmem_req from the next cycle.
REQ-012 SHALL hold o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be and o_dmem_wdata stable in ACCESS until the cycle in which i_dmem_ack=1.
- On that edge the FSM SHALL return to IDLE and deassert o_dmem_req.
REQ-013 SHALL ignore i_dmem_ack while in IDLE.
REQ-014 SHALL form store lanes as follows:
- SB (func3=0): be=4'b0001<<addr[1:0], wdata = byte replicated x4.
- SH (func3=1): be=4'b0011<<{addr[1],1'b0}, wdata = halfword replicated x2.
- SW (func3=2): be=4'b1111.
REQ-015 SHALL extract and extend loads from i_dmem_rdata at ack:
- LB=0 and LH=1 sign-extend.
- LW=2 is unmodified.
- LBU=4 and LHU=5 zero-extend.
- The lane is selected by addr[1:0].
REQ-016 SHALL present a load result with o_wb_valid=1 and o_wb_data = extended data in the cycle after ack (load latency = 1 + ack wait + 1).
REQ-017 SHALL signal a store completion with o_wb_valid=1 and o_wb_reg_write=0 in the cycle after ack.
REQ-018 SHALL treat the following as an error: LH/SH/LHU with addr[0]=1, LW/SW with addr[1:0]!=0, or func3 in {3,6,7} on a memory op. On an error the block SHALL:
- issue no request;
- stay in IDLE;
- pulse o_misaligned for 1 cycle;
- emit o_wb_valid=1 with o_wb_reg_write=0.
REQ-019 SHALL treat simultaneous i_mem_read and i_mem_write as a store.
REQ-020 SHALL make o_wb_valid, o_misaligned and o_bus_err single-cycle pulses; all WB outputs SHALL be registered.

Reset
REQ-021 SHALL, while i_reset=0 and independent of i_clk, force: state=IDLE, o_stall=0, o_dmem_req=0, o_dmem_we=0, o_dmem_addr=0, o_dmem_be=0, o_dmem_wdata=0, o_wb_valid=0, o_wb_rd=0, o_wb_reg_write=0, o_wb_data=0, o_misaligned=0, o_bus_err=0, timeout counter=0.
REQ-022 SHALL abandon an access when reset is asserted during ACCESS; no WB pulse SHALL follow, and a late ack after reset SHALL be ignored.

Configuration
REQ-023 SHALL, with MEM_ACK_TIMEOUT_EN defined:
- count cycles in ACCESS;
- if TIMEOUT_CYC cycles elapse without ack, drop o_dmem_req, return to IDLE, pulse o_bus_err, and emit o_wb_valid=1 with o_wb_reg_write=0;
- reset the counter on each entry to ACCESS.
REQ-024 SHALL, without MEM_ACK_TIMEOUT_EN, wait for ack indefinitely, tie o_bus_err to 0, and contain no counter.

Verification
REQ-025 ADD result 0x00000042 with rd=5 and reg_write=1 -> o_wb_valid, o_wb_rd=5 and o_wb_data=0x42 one cycle later, with no dmem_req.
REQ-026 SB at addr 0x103 with rd2=0x000000A5, ack after 3 cycles -> be=4'b1000, wdata=0xA5A5A5A5, o_stall high 4 cycles, addr 0x100 stable throughout.
REQ-027 LB at 0x202 with rdata 0x00800000 -> o_wb_data=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-028 LW at 0x301 -> o_misaligned pulse, no o_dmem_req, o_wb_reg_write=0.
REQ-029 LW, then i_reset=0 asserted 1 cycle into ACCESS, then ack -> all outputs 0 and no o_wb_valid.
REQ-030 With MEM_ACK_TIMEOUT_EN and TIMEOUT_CYC=16, LW never acked -> req dropped after 16 cycles, o_bus_err pulse, o_stall low the following cycle.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage between EX/MEM and WB.
// Non-memory ops pass to WB with one cycle of latency. Loads and stores
// are issued on a req/ack data-memory port, and the EX stage is stalled
// until the access completes.
// Optional build macro MEM_ACK_TIMEOUT_EN: abandons an access that has
// waited TIMEOUT_CYC cycles without ack and pulses o_bus_err. Without the
// macro the stage waits for ack indefinitely and o_bus_err is tied low.
//
// Handshakes:
//   EX -> MEM: an op transfers on a rising edge where i_valid=1 and o_stall=0.
//   MEM -> dmem: o_dmem_req rises the cycle after a memory op is accepted.
//     req, we, addr, be and wdata then stay constant until the edge that
//     samples i_dmem_ack=1. On that edge the access completes and req falls.
//     An ack seen while no request is outstanding has no effect.
module mem_stage #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic [31:0] i_alu_out,
    input  logic [31:0] i_rd2,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_func3,
    input  logic [4:0]  i_rd,
    input  logic        i_reg_write,
    input  logic        i_mem_to_reg,
    output logic        o_stall,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_be,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_wb_valid,
    output logic [4:0]  o_wb_rd,
    output logic        o_wb_reg_write,
    output logic [31:0] o_wb_data,
    output logic        o_misaligned,
    output logic        o_bus_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lane_q, lane_d;
    logic [4:0]  rd_q, rd_d;
    logic        rw_q, rw_d;
    logic        m2r_q, m2r_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_rw_q, wb_rw_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        mis_q, mis_d;

`ifdef MEM_ACK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             berr_q, berr_d;
`endif

    logic        is_mem;
    logic        bad_op;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign is_mem = i_mem_read | i_mem_write;

    // Byte-lane mask and replicated write data for the incoming op; the
    // low two func3 bits give the access size.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = i_rd2;
        case (i_func3[1:0])
            2'd0: begin
                st_be    = 4'b0001 << i_alu_out[1:0];
                st_wdata = {4{i_rd2[7:0]}};
            end
            2'd1: begin
                st_be    = 4'b0011 << {i_alu_out[1], 1'b0};
                st_wdata = {2{i_rd2[15:0]}};
            end
            default: ;
        endcase
    end

    // Reject reserved size codes and accesses that cross their natural alignment.
    always_comb begin
        bad_op = 1'b0;
        if (i_func3 == 3'd3 || i_func3 == 3'd6 || i_func3 == 3'd7)
            bad_op = 1'b1;
        else if (i_func3[1:0] == 2'd1 && i_alu_out[0])
            bad_op = 1'b1;
        else if (i_func3[1:0] == 2'd2 && i_alu_out[1:0] != 2'd0)
            bad_op = 1'b1;
    end

    // Select the addressed lane of the returned word, then sign- or zero-extend it.
    always_comb begin
        ld_byte = 8'h00;
        case (lane_q)
            2'd0: ld_byte = i_dmem_rdata[7:0];
            2'd1: ld_byte = i_dmem_rdata[15:8];
            2'd2: ld_byte = i_dmem_rdata[23:16];
            2'd3: ld_byte = i_dmem_rdata[31:24];
            default: ;
        endcase
        ld_half = lane_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        case (f3_q)
            3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_ext = {24'h000000, ld_byte};
            3'd5:    ld_ext = {16'h0000, ld_half};
            default: ld_ext = i_dmem_rdata;
        endcase
    end

    // Next-state logic: accept ops in IDLE, wait for ack in ACCESS, and
    // form the one-cycle WB, misalignment and bus-error pulses.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        f3_d       = f3_q;
        lane_d     = lane_q;
        rd_d       = rd_q;
        rw_d       = rw_q;
        m2r_d      = m2r_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_rw_d    = 1'b0;
        wb_data_d  = wb_data_q;
        mis_d      = 1'b0;
`ifdef MEM_ACK_TIMEOUT_EN
        cnt_d      = cnt_q;
        berr_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    if (!is_mem) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = i_rd;
                        wb_rw_d    = i_reg_write;
                        wb_data_d  = i_alu_out;
                    end else if (bad_op) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = i_rd;
                        mis_d      = 1'b1;
                    end else begin
                        state_d = ACCESS;
                        req_d   = 1'b1;
                        // A read+write op is handled as a store.
                        we_d    = i_mem_write;
                        addr_d  = {i_alu_out[31:2], 2'b00};
                        be_d    = st_be;
                        wdata_d = st_wdata;
                        f3_d    = i_func3;
                        lane_d  = i_alu_out[1:0];
                        rd_d    = i_rd;
                        rw_d    = i_reg_write;
                        m2r_d   = i_mem_to_reg;
`ifdef MEM_ACK_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            ACCESS: begin
                if (i_dmem_ack) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    if (we_q) begin
                        wb_data_d = 32'h0;
                    end else begin
                        wb_rw_d   = rw_q;
                        // Classic WB mux: without mem_to_reg the op
                        // writes back its address result.
                        wb_data_d = m2r_q ? ld_ext : {addr_q[31:2], lane_q};
                    end
                end
`ifdef MEM_ACK_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    berr_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any outstanding access.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            be_q       <= 4'h0;
            wdata_q    <= 32'h0;
            f3_q       <= 3'd0;
            lane_q     <= 2'd0;
            rd_q       <= 5'd0;
            rw_q       <= 1'b0;
            m2r_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_rw_q    <= 1'b0;
            wb_data_q  <= 32'h0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            f3_q       <= f3_d;
            lane_q     <= lane_d;
            rd_q       <= rd_d;
            rw_q       <= rw_d;
            m2r_q      <= m2r_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_rw_q    <= wb_rw_d;
            wb_data_q  <= wb_data_d;
            mis_q      <= mis_d;
        end
    end

`ifdef MEM_ACK_TIMEOUT_EN
    // Ack-wait counter and bus-error pulse.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q  <= '0;
            berr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            berr_q <= berr_d;
        end
    end
    assign o_bus_err = berr_q;
`else
    assign o_bus_err = 1'b0;
`endif

    assign o_stall        = (state_q == ACCESS);
    assign o_dmem_req     = req_q;
    assign o_dmem_we      = we_q;
    assign o_dmem_addr    = addr_q;
    assign o_dmem_be      = be_q;
    assign o_dmem_wdata   = wdata_q;
    assign o_wb_valid     = wb_valid_q;
    assign o_wb_rd        = wb_rd_q;
    assign o_wb_reg_write = wb_rw_q;
    assign o_wb_data      = wb_data_q;
    assign o_misaligned   = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: pass-through ops, store lanes, load
// extension, misalignment, reset mid-access and ack-wait behaviour.
module tb_mem_stage;

    logic        i_clk;
    logic        i_reset;
    logic        i_valid;
    logic [31:0] i_alu_out;
    logic [31:0] i_rd2;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [2:0]  i_func3;
    logic [4:0]  i_rd;
    logic        i_reg_write;
    logic        i_mem_to_reg;
    logic        o_stall;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;
    logic        o_wb_valid;
    logic [4:0]  o_wb_rd;
    logic        o_wb_reg_write;
    logic [31:0] o_wb_data;
    logic        o_misaligned;
    logic        o_bus_err;

    int n_chk;
    int n_bad;
    int seen;

    mem_stage #(.TIMEOUT_CYC(16)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_valid       (i_valid),
        .i_alu_out     (i_alu_out),
        .i_rd2         (i_rd2),
        .i_mem_read    (i_mem_read),
        .i_mem_write   (i_mem_write),
        .i_func3       (i_func3),
        .i_rd          (i_rd),
        .i_reg_write   (i_reg_write),
        .i_mem_to_reg  (i_mem_to_reg),
        .o_stall       (o_stall),
        .o_dmem_req    (o_dmem_req),
        .o_dmem_we     (o_dmem_we),
        .o_dmem_addr   (o_dmem_addr),
        .o_dmem_be     (o_dmem_be),
        .o_dmem_wdata  (o_dmem_wdata),
        .i_dmem_ack    (i_dmem_ack),
        .i_dmem_rdata  (i_dmem_rdata),
        .o_wb_valid    (o_wb_valid),
        .o_wb_rd       (o_wb_rd),
        .o_wb_reg_write(o_wb_reg_write),
        .o_wb_data     (o_wb_data),
        .o_misaligned  (o_misaligned),
        .o_bus_err     (o_bus_err)
    );

    // Clock
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, o_stall, 0);
        chk({tag, "_req"}, o_dmem_req, 0);
        chk({tag, "_we"}, o_dmem_we, 0);
        chk({tag, "_addr"}, o_dmem_addr, 0);
        chk({tag, "_be"}, o_dmem_be, 0);
        chk({tag, "_wdata"}, o_dmem_wdata, 0);
        chk({tag, "_wbv"}, o_wb_valid, 0);
        chk({tag, "_wbrd"}, o_wb_rd, 0);
        chk({tag, "_wbrw"}, o_wb_reg_write, 0);
        chk({tag, "_wbdata"}, o_wb_data, 0);
        chk({tag, "_mis"}, o_misaligned, 0);
        chk({tag, "_berr"}, o_bus_err, 0);
    endtask

    // Present one op for a single accepting edge, then drop i_valid.
    task automatic drive_op(input logic [31:0] alu, input logic [31:0] rd2,
                            input logic mr, input logic mw, input logic [2:0] f3,
                            input logic [4:0] rd, input logic rw);
        i_valid      = 1'b1;
        i_alu_out    = alu;
        i_rd2        = rd2;
        i_mem_read   = mr;
        i_mem_write  = mw;
        i_func3      = f3;
        i_rd         = rd;
        i_reg_write  = rw;
        i_mem_to_reg = mr;
        tick();
        i_valid     = 1'b0;
        i_mem_read  = 1'b0;
        i_mem_write = 1'b0;
    endtask

    // Hold off ack for wait_cyc cycles, then ack with rdata for one cycle.
    task automatic do_access(input int wait_cyc, input logic [31:0] rdata,
                             input logic [31:0] exp_addr, output int stall_seen);
        stall_seen = 0;
        for (int i = 0; i <= wait_cyc; i++) begin
            if (o_stall) stall_seen++;
            chk("req_hold", o_dmem_req, 1);
            chk("addr_hold", o_dmem_addr, exp_addr);
            chk("berr_quiet", o_bus_err, 0);
            if (i == wait_cyc) begin
                i_dmem_ack   = 1'b1;
                i_dmem_rdata = rdata;
            end
            tick();
            i_dmem_ack   = 1'b0;
            i_dmem_rdata = 32'h0;
        end
        chk("req_drop", o_dmem_req, 0);
        chk("stall_drop", o_stall, 0);
    endtask

    task automatic load_case(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] rdata, input logic [31:0] exp);
        int s;
        drive_op(addr, 32'h0, 1'b1, 1'b0, f3, 5'd9, 1'b1);
        chk({tag, "_we"}, o_dmem_we, 0);
        do_access(0, rdata, {addr[31:2], 2'b00}, s);
        chk({tag, "_wbv"}, o_wb_valid, 1);
        chk({tag, "_data"}, o_wb_data, exp);
        chk({tag, "_rw"}, o_wb_reg_write, 1);
        chk({tag, "_rd"}, o_wb_rd, 9);
        tick();
        chk({tag, "_wbv_pulse"}, o_wb_valid, 0);
    endtask

    task automatic store_case(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] rd2, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata);
        int s;
        drive_op(addr, rd2, 1'b0, 1'b1, f3, 5'd3, 1'b0);
        chk({tag, "_we"}, o_dmem_we, 1);
        chk({tag, "_be"}, o_dmem_be, exp_be);
        chk({tag, "_wdata"}, o_dmem_wdata, exp_wdata);
        do_access(1, 32'h0, {addr[31:2], 2'b00}, s);
        chk({tag, "_wbv"}, o_wb_valid, 1);
        chk({tag, "_rw"}, o_wb_reg_write, 0);
        tick();
    endtask

    initial begin
        n_chk        = 0;
        n_bad        = 0;
        i_reset      = 1'b0;
        i_valid      = 1'b0;
        i_alu_out    = 32'h0;
        i_rd2        = 32'h0;
        i_mem_read   = 1'b0;
        i_mem_write  = 1'b0;
        i_func3      = 3'd0;
        i_rd         = 5'd0;
        i_reg_write  = 1'b0;
        i_mem_to_reg = 1'b0;
        i_dmem_ack   = 1'b0;
        i_dmem_rdata = 32'h0;

        // Reset state
        #3;
        chk_all_zero("rst");
        tick();
        tick();
        i_reset = 1'b1;
        tick();

        // Non-memory op: ADD result to WB one cycle later
        drive_op(32'h42, 32'h0, 1'b0, 1'b0, 3'd0, 5'd5, 1'b1);
        chk("add_wbv", o_wb_valid, 1);
        chk("add_rd", o_wb_rd, 5);
        chk("add_data", o_wb_data, 32'h42);
        chk("add_rw", o_wb_reg_write, 1);
        chk("add_req", o_dmem_req, 0);
        chk("add_stall", o_stall, 0);
        tick();
        chk("add_wbv_pulse", o_wb_valid, 0);

        // SB at 0x103, ack on the 4th request cycle
        drive_op(32'h103, 32'h000000A5, 1'b0, 1'b1, 3'd0, 5'd0, 1'b0);
        chk("sb_be", o_dmem_be, 4'b1000);
        chk("sb_wdata", o_dmem_wdata, 32'hA5A5A5A5);
        chk("sb_we", o_dmem_we, 1);
        do_access(3, 32'h0, 32'h100, seen);
        chk("sb_stall_cycles", seen, 4);
        chk("sb_wbv", o_wb_valid, 1);
        chk("sb_rw", o_wb_reg_write, 0);
        tick();
        chk("sb_wbv_pulse", o_wb_valid, 0);

        // Other store sizes
        store_case("sh", 3'd1, 32'h206, 32'h1234ABCD, 4'b1100, 32'hABCDABCD);
        store_case("sw", 3'd2, 32'h400, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);

        // Loads with lane select and extension
        load_case("lb", 3'd0, 32'h202, 32'h00800000, 32'hFFFFFF80);
        load_case("lbu", 3'd4, 32'h202, 32'h00800000, 32'h00000080);
        load_case("lh", 3'd1, 32'h202, 32'h80010000, 32'hFFFF8001);
        load_case("lhu", 3'd5, 32'h200, 32'h1234F00D, 32'h0000F00D);
        load_case("lw", 3'd2, 32'h300, 32'hDEADBEEF, 32'hDEADBEEF);

        // Ack while idle has no effect
        i_dmem_ack = 1'b1;
        tick();
        i_dmem_ack = 1'b0;
        chk("idle_ack_wbv", o_wb_valid, 0);
        chk("idle_ack_stall", o_stall, 0);

        // Misaligned LW at 0x301
        drive_op(32'h301, 32'h0, 1'b1, 1'b0, 3'd2, 5'd7, 1'b1);
        chk("mis_pulse", o_misaligned, 1);
        chk("mis_wbv", o_wb_valid, 1);
        chk("mis_rw", o_wb_reg_write, 0);
        chk("mis_req", o_dmem_req, 0);
        chk("mis_stall", o_stall, 0);
        tick();
        chk("mis_pulse_end", o_misaligned, 0);
        chk("mis_req_after", o_dmem_req, 0);

        // Reserved func3 on a load
        drive_op(32'h300, 32'h0, 1'b1, 1'b0, 3'd3, 5'd7, 1'b1);
        chk("f3bad_pulse", o_misaligned, 1);
        chk("f3bad_req", o_dmem_req, 0);
        tick();

        // Read and write together behave as a store
        drive_op(32'h500, 32'h55AA55AA, 1'b1, 1'b1, 3'd2, 5'd4, 1'b1);
        chk("rw_both_we", o_dmem_we, 1);
        do_access(0, 32'h0, 32'h500, seen);
        chk("rw_both_rw", o_wb_reg_write, 0);
        tick();

        // Reset one cycle into an access, then a late ack
        drive_op(32'h600, 32'h0, 1'b1, 1'b0, 3'd2, 5'd8, 1'b1);
        tick();
        chk("rstmid_stall", o_stall, 1);
        i_reset = 1'b0;
        #1;
        chk_all_zero("rstmid");
        tick();
        chk("rstmid_wbv", o_wb_valid, 0);
        tick();
        i_reset    = 1'b1;
        i_dmem_ack = 1'b1;
        tick();
        i_dmem_ack = 1'b0;
        chk("late_ack_wbv", o_wb_valid, 0);
        chk("late_ack_stall", o_stall, 0);
        chk("late_ack_req", o_dmem_req, 0);
        tick();
        chk("late_ack_wbv2", o_wb_valid, 0);

`ifdef MEM_ACK_TIMEOUT_EN
        // LW never acked: abandoned after 16 cycles
        drive_op(32'h700, 32'h0, 1'b1, 1'b0, 3'd2, 5'd2, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk("to_req", o_dmem_req, 1);
            chk("to_berr_quiet", o_bus_err, 0);
            tick();
        end
        chk("to_req_drop", o_dmem_req, 0);
        chk("to_stall", o_stall, 0);
        chk("to_berr", o_bus_err, 1);
        chk("to_wbv", o_wb_valid, 1);
        chk("to_rw", o_wb_reg_write, 0);
        tick();
        chk("to_berr_pulse", o_bus_err, 0);
        chk("to_wbv_pulse", o_wb_valid, 0);
`else
        // Long ack wait: no timeout, ack still completes the load
        drive_op(32'h700, 32'h0, 1'b1, 1'b0, 3'd2, 5'd2, 1'b1);
        do_access(20, 32'h11223344, 32'h700, seen);
        chk("long_stall_cycles", seen, 21);
        chk("long_wbv", o_wb_valid, 1);
        chk("long_data", o_wb_data, 32'h11223344);
        chk("long_berr", o_bus_err, 0);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
